// File: rtl/avst_pkt_fifo.sv
// rtl/avst_pkt_fifo.sv - store-and-forward Avalon-ST packet FIFO with drop of bad packets
module avst_pkt_fifo #(
    parameter int DATA_W    = 128,
    parameter int EMPTY_W   = 4,
    parameter int CHANNEL_W = 128,
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 avst_in_ready,
    input  logic                 avst_in_valid,
    input  logic                 avst_in_startofpacket,
    input  logic [DATA_W-1:0]    avst_in_data,
    input  logic [EMPTY_W-1:0]   avst_in_empty,
    input  logic                 avst_in_endofpacket,
    input  logic [CHANNEL_W-1:0] avst_in_channel,
    input  logic                 avst_out_ready,
    output logic                 avst_out_valid,
    output logic                 avst_out_startofpacket,
    output logic [DATA_W-1:0]    avst_out_data,
    output logic [EMPTY_W-1:0]   avst_out_empty,
    output logic                 avst_out_endofpacket,
    output logic [CHANNEL_W-1:0] avst_out_channel,
    output logic [ADDR_W:0]      pkt_cnt,
    output logic [15:0]          drop_cnt
);

    typedef struct packed {
        logic                 sop;
        logic                 eop;
        logic [EMPTY_W-1:0]   empty;
        logic [CHANNEL_W-1:0] channel;
        logic [DATA_W-1:0]    data;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_WR, S_DROP} wr_state_t;

    localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);

    entry_t mem [DEPTH];

    wr_state_t       state_q, state_d;
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] wr_base_q, wr_base_d;
    logic [ADDR_W:0] commit_q, commit_d;
    logic [ADDR_W:0] fetch_q;
    logic [ADDR_W:0] rd_ptr_q;
    logic            in_ready_q;
    entry_t          s1_q, out_q;
    logic            s1_v_q, out_v_q;
    logic [ADDR_W:0] pkt_cnt_q;
    logic [15:0]     drop_cnt_q;

    logic            in_fire, wr_en, commit_en, restart;
    logic [ADDR_W:0] wp;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]      drop_add;
    logic            out_fire, s1_load, s2_load, pkt_dec;
    logic [16:0]     drop_sum;
    entry_t          in_entry;

    assign in_fire  = avst_in_valid & in_ready_q;
    assign in_entry = '{sop: avst_in_startofpacket, eop: avst_in_endofpacket,
                        empty: avst_in_empty, channel: avst_in_channel, data: avst_in_data};

    // Write FSM: speculative write, rewind on bad packet, commit on eop.
    // rd_ptr_q only advances when a beat leaves the block, so beats still
    // in the read pipeline keep their RAM slot and pkt_cnt stays <= DEPTH.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        wr_base_d = wr_base_q;
        commit_d  = commit_q;
        wr_en     = 1'b0;
        commit_en = 1'b0;
        drop_add  = 2'd0;
        restart   = 1'b0;
        wp        = wr_ptr_q;
        wr_addr   = wr_ptr_q[ADDR_W-1:0];
        if (in_fire) begin
            case (state_q)
                S_IDLE: restart = 1'b1;
                S_WR: begin
                    if (avst_in_startofpacket) begin
                        drop_add = 2'd1;
                        wp       = wr_base_q;
                        restart  = 1'b1;
                    end else if ((wr_ptr_q - rd_ptr_q) == DEPTH_P) begin
                        wr_ptr_d = wr_base_q;
                        drop_add = 2'd1;
                        state_d  = avst_in_endofpacket ? S_IDLE : S_DROP;
                    end else begin
                        wr_en    = 1'b1;
                        wr_addr  = wr_ptr_q[ADDR_W-1:0];
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (avst_in_endofpacket) begin
                            commit_en = 1'b1;
                            commit_d  = wr_ptr_q + 1'b1;
                            state_d   = S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    if (avst_in_startofpacket) begin
                        restart = 1'b1;
                    end else if (avst_in_endofpacket) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            // A sop beat (or a stray beat in IDLE) is handled from the IDLE rules,
            // against the possibly rewound pointer.
            if (restart) begin
                if (!avst_in_startofpacket) begin
                    state_d = S_IDLE;
                end else if ((wp - rd_ptr_q) == DEPTH_P) begin
                    wr_ptr_d = wp;
                    drop_add = drop_add + 2'd1;
                    state_d  = avst_in_endofpacket ? S_IDLE : S_DROP;
                end else begin
                    wr_en     = 1'b1;
                    wr_addr   = wp[ADDR_W-1:0];
                    wr_base_d = wp;
                    wr_ptr_d  = wp + 1'b1;
                    if (avst_in_endofpacket) begin
                        commit_en = 1'b1;
                        commit_d  = wp + 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        state_d   = S_WR;
                    end
                end
            end
        end
    end

    // Beat storage, no reset needed: only committed slots are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= in_entry;
        end
    end

    assign out_fire = out_v_q & avst_out_ready;
    assign s2_load  = s1_v_q & (~out_v_q | avst_out_ready);
    assign s1_load  = (fetch_q != commit_q) & (~s1_v_q | s2_load);
    assign pkt_dec  = out_fire & out_q.eop;
    assign drop_sum = {1'b0, drop_cnt_q} + {15'd0, drop_add};

    // Write-side state, counters, and the two-stage read pipeline (RAM register + output register).
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            wr_base_q  <= '0;
            commit_q   <= '0;
            fetch_q    <= '0;
            rd_ptr_q   <= '0;
            in_ready_q <= 1'b0;
            s1_q       <= '0;
            s1_v_q     <= 1'b0;
            out_q      <= '0;
            out_v_q    <= 1'b0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_base_q  <= wr_base_d;
            commit_q   <= commit_d;
            in_ready_q <= 1'b1;
            if (s1_load) begin
                s1_q    <= mem[fetch_q[ADDR_W-1:0]];
                fetch_q <= fetch_q + 1'b1;
            end
            s1_v_q <= s1_load | (s1_v_q & ~s2_load);
            if (s2_load) begin
                out_q <= s1_q;
            end
            out_v_q <= s2_load | (out_v_q & ~avst_out_ready);
            if (out_fire) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            pkt_cnt_q  <= pkt_cnt_q + {{ADDR_W{1'b0}}, commit_en} - {{ADDR_W{1'b0}}, pkt_dec};
            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign avst_in_ready          = in_ready_q;
    assign avst_out_valid         = out_v_q;
    assign avst_out_startofpacket = out_q.sop;
    assign avst_out_endofpacket   = out_q.eop;
    assign avst_out_empty         = out_q.empty;
    assign avst_out_channel       = out_q.channel;
    assign avst_out_data          = out_q.data;
    assign pkt_cnt                = pkt_cnt_q;
    assign drop_cnt               = drop_cnt_q;

endmodule

// File: tb/tb_avst_pkt_fifo.sv
// tb/tb_avst_pkt_fifo.sv - scoreboard bench for avst_pkt_fifo against a packet-level model
module tb_avst_pkt_fifo;

    localparam int DATA_W = 128, EMPTY_W = 4, CHANNEL_W = 128, DEPTH = 64, ADDR_W = 6;

    typedef struct packed {
        logic                 sop;
        logic                 eop;
        logic [EMPTY_W-1:0]   empty;
        logic [CHANNEL_W-1:0] channel;
        logic [DATA_W-1:0]    data;
    } beat_t;

    logic                 clk, reset;
    logic                 avst_in_ready, avst_in_valid, avst_in_startofpacket, avst_in_endofpacket;
    logic [DATA_W-1:0]    avst_in_data;
    logic [EMPTY_W-1:0]   avst_in_empty;
    logic [CHANNEL_W-1:0] avst_in_channel;
    logic                 avst_out_ready, avst_out_valid, avst_out_startofpacket, avst_out_endofpacket;
    logic [DATA_W-1:0]    avst_out_data;
    logic [EMPTY_W-1:0]   avst_out_empty;
    logic [CHANNEL_W-1:0] avst_out_channel;
    logic [ADDR_W:0]      pkt_cnt;
    logic [15:0]          drop_cnt;

    avst_pkt_fifo #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CHANNEL_W(CHANNEL_W),
                    .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .avst_in_ready(avst_in_ready), .avst_in_valid(avst_in_valid),
        .avst_in_startofpacket(avst_in_startofpacket), .avst_in_data(avst_in_data),
        .avst_in_empty(avst_in_empty), .avst_in_endofpacket(avst_in_endofpacket),
        .avst_in_channel(avst_in_channel),
        .avst_out_ready(avst_out_ready), .avst_out_valid(avst_out_valid),
        .avst_out_startofpacket(avst_out_startofpacket), .avst_out_data(avst_out_data),
        .avst_out_empty(avst_out_empty), .avst_out_endofpacket(avst_out_endofpacket),
        .avst_out_channel(avst_out_channel),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    int    checks = 0;
    int    errors = 0;
    int    rdy_mode = 0;
    bit    chk_en = 0;
    beat_t exp_q[$];
    beat_t pkt_buf[$];
    bit    in_pkt = 0;
    int    m_drop = 0, m_commits = 0, m_eops = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream ready pattern: 0 = stalled, 1 = always ready, 2 = random.
    initial begin
        avst_out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       avst_out_ready = 1'b0;
                1:       avst_out_ready = 1'b1;
                default: avst_out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Packet-level reference: a packet survives if it starts with sop, reaches eop
    // before any other sop, and is no longer than DEPTH beats.
    function automatic void model_accept(input beat_t b);
        if (b.sop) begin
            if (in_pkt) m_drop++;
            pkt_buf.delete();
            in_pkt = 1;
            pkt_buf.push_back(b);
        end else if (in_pkt) begin
            pkt_buf.push_back(b);
        end else begin
            return;
        end
        if (pkt_buf.size() > DEPTH) begin
            m_drop++;
            in_pkt = 0;
            pkt_buf.delete();
        end else if (b.eop) begin
            foreach (pkt_buf[i]) exp_q.push_back(pkt_buf[i]);
            m_commits++;
            in_pkt = 0;
            pkt_buf.delete();
        end
    endfunction

    // Monitor: counters every cycle, hold-stability under stall, and output beats against the scoreboard.
    beat_t prev_beat;
    bit    prev_stall = 0;
    always @(negedge clk) begin
        beat_t cur, e;
        cur = '{sop: avst_out_startofpacket, eop: avst_out_endofpacket, empty: avst_out_empty,
                channel: avst_out_channel, data: avst_out_data};
        if (chk_en) begin
            chk("pkt_cnt", 64'(pkt_cnt), 64'(m_commits - m_eops));
            chk("pkt_cnt_max", 64'(pkt_cnt <= 7'(DEPTH)), 64'd1);
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
            if (prev_stall) begin
                chk("hold_valid", 64'(avst_out_valid), 64'd1);
                checks++;
                if (cur !== prev_beat) begin
                    errors++;
                    $display("FAIL hold_fields actual=%h required=%h", cur, prev_beat);
                end
            end
            if (avst_out_valid && avst_out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat actual=%h required=none", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL out_beat actual=%h required=%h", cur, e);
                    end
                    if (e.eop) m_eops++;
                end
            end
            prev_stall = avst_out_valid && !avst_out_ready;
            prev_beat  = cur;
        end else begin
            prev_stall = 0;
        end
    end

    task automatic drive_beat(input beat_t b);
        avst_in_valid         = 1'b1;
        avst_in_startofpacket = b.sop;
        avst_in_endofpacket   = b.eop;
        avst_in_empty         = b.empty;
        avst_in_channel       = b.channel;
        avst_in_data          = b.data;
        chk("in_ready", 64'(avst_in_ready), 64'd1);
        @(posedge clk);
        model_accept(b);
        #1;
        avst_in_valid = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Beats of a packet; with no_eop the last beat lacks eop.
    task automatic send_pkt(input int len, input bit no_eop, input bit gaps);
        beat_t b;
        logic [127:0] ch;
        ch = rnd128();
        for (int i = 0; i < len; i++) begin
            b.sop     = (i == 0);
            b.eop     = (i == len - 1) && !no_eop;
            b.empty   = b.eop ? 4'($urandom_range(0, 15)) : 4'd0;
            b.channel = ch;
            b.data    = rnd128();
            drive_beat(b);
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic do_reset();
        chk_en        = 0;
        reset         = 1'b0;
        avst_in_valid = 1'b0;
        exp_q.delete();
        pkt_buf.delete();
        in_pkt = 0; m_drop = 0; m_commits = 0; m_eops = 0;
        @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(avst_out_valid), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_in_ready", 64'(avst_in_ready), 64'd0);
        chk("rst_out_fields", 64'({avst_out_startofpacket, avst_out_endofpacket, avst_out_empty}
                                  | avst_out_data[63:0] | avst_out_channel[63:0]), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", 64'(avst_in_ready), 64'd1);
        chk_en = 1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || avst_out_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(n < 3000), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        beat_t b;
        logic [127:0] first_data;
        reset                 = 1'b0;
        avst_in_valid         = 1'b0;
        avst_in_startofpacket = 1'b0;
        avst_in_endofpacket   = 1'b0;
        avst_in_empty         = '0;
        avst_in_channel       = '0;
        avst_in_data          = '0;
        do_reset();

        // 3-beat packet, latency to first output beat.
        rdy_mode = 1;
        for (int i = 0; i < 3; i++) begin
            b = '{sop: (i == 0), eop: (i == 2), empty: (i == 2) ? 4'd5 : 4'd0,
                  channel: 128'hA, data: 128'(i + 1)};
            drive_beat(b);
        end
        chk("t1_valid_T", 64'(avst_out_valid), 64'd0);
        chk("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);
        @(posedge clk); #1;
        chk("t1_valid_T1", 64'(avst_out_valid), 64'd0);
        @(posedge clk); #1;
        chk("t1_valid_T2", 64'(avst_out_valid), 64'd1);
        chk("t1_sop", 64'(avst_out_startofpacket), 64'd1);
        chk("t1_data0", 64'(avst_out_data), 64'd1);
        wait_drain();
        chk("t1_pkt_cnt_end", 64'(pkt_cnt), 64'd0);

        // 10-beat packet with downstream stalled, then a 1 beat/clk burst.
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        first_data = '0;
        for (int i = 0; i < 10; i++) begin
            b = '{sop: (i == 0), eop: (i == 9), empty: 4'd0, channel: 128'h5, data: rnd128()};
            if (i == 0) first_data = b.data;
            chk("t2_no_early_valid", 64'(avst_out_valid), 64'd0);
            drive_beat(b);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("t2_valid_held", 64'(avst_out_valid), 64'd1);
        chk("t2_sop0", 64'(avst_out_startofpacket), 64'd1);
        chk("t2_data0", avst_out_data[63:0], first_data[63:0]);
        repeat (3) @(posedge clk);
        #1;
        rdy_mode = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t2_burst_valid", 64'(avst_out_valid), 64'd1);
        end
        @(negedge clk);
        chk("t2_burst_end", 64'(avst_out_valid), 64'd0);
        @(posedge clk); #1;
        wait_drain();

        // Oversized packets: 70 dropped, 64 fits, 65 dropped.
        send_pkt(70, 0, 0);
        send_pkt(2, 0, 0);
        wait_drain();
        chk("t3_drop70", 64'(drop_cnt), 64'd1);
        send_pkt(64, 0, 0);
        wait_drain();
        send_pkt(65, 0, 0);
        send_pkt(1, 0, 0);
        wait_drain();
        chk("t3_drop65", 64'(drop_cnt), 64'd2);

        // Missing eop, then a new sop starting a 3-beat packet.
        do_reset();
        rdy_mode = 1;
        send_pkt(2, 1, 0);
        send_pkt(3, 0, 0);
        wait_drain();
        chk("t4_drop", 64'(drop_cnt), 64'd1);

        // Back-to-back single-beat packets with random downstream ready.
        do_reset();
        rdy_mode = 2;
        for (int i = 0; i < 50; i++) send_pkt(1, 0, 0);
        wait_drain();
        chk("t5_drop", 64'(drop_cnt), 64'd0);

        // Random mix of good packets, truncated packets and stray beats.
        for (int r = 0; r < 20; r++) begin
            rdy_mode = $urandom_range(1, 2);
            for (int k = 0; k < int'($urandom_range(1, 5)); k++) begin
                case ($urandom_range(0, 9))
                    0: send_pkt($urandom_range(1, 8), 1, 1);
                    1: begin
                        b = '{sop: 1'b0, eop: 1'($urandom_range(0, 1)), empty: 4'd0,
                              channel: rnd128(), data: rnd128()};
                        drive_beat(b);
                    end
                    default: send_pkt($urandom_range(1, 8), 0, 1);
                endcase
            end
            send_pkt($urandom_range(1, 8), 0, 1);
            wait_drain();
        end

        // Reset with a committed packet stalled on the output and a packet half written.
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        send_pkt(4, 0, 0);
        send_pkt(2, 1, 0);
        @(posedge clk); #1;
        chk("t6_valid_before", 64'(avst_out_valid), 64'd1);
        do_reset();
        rdy_mode = 1;
        send_pkt(3, 0, 0);
        wait_drain();
        chk("t6_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("t6_drop", 64'(drop_cnt), 64'd0);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avst_pkt_fifo.md
Name: avst_pkt_fifo

Overview:
- Store-and-forward Avalon-ST packet FIFO on the narrow (128-bit) side of the width converter.
- Consumes the divide output stream (512->128). Re-times it and releases a packet downstream only once its eop beat is stored.
- Incomplete, malformed or overflowing packets are discarded and counted. Downstream never sees a truncated packet.

Parameters:
DATA_W, 128, data beat width
EMPTY_W, 4, empty field width (log2 of DATA_W/8)
CHANNEL_W, 128, channel field width
DEPTH, 64, beat storage; power of two, >= 4
ADDR_W, 6, log2(DEPTH)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-low reset
avst_in_ready  out  1  input ready
avst_in_valid  in  1  input beat valid
avst_in_startofpacket  in  1  sop
avst_in_data  in  DATA_W  beat data
avst_in_empty  in  EMPTY_W  empty bytes (eop beat only)
avst_in_endofpacket  in  1  eop
avst_in_channel  in  CHANNEL_W  channel, captured on every beat
avst_out_ready  in  1  downstream ready
avst_out_valid  out  1  output beat valid
avst_out_startofpacket  out  1  sop
avst_out_data  out  DATA_W  beat data
avst_out_empty  out  EMPTY_W  empty
avst_out_endofpacket  out  1  eop
avst_out_channel  out  CHANNEL_W  channel
pkt_cnt  out  ADDR_W+1  complete packets held
drop_cnt  out  16  dropped packets, saturating

Behaviour:
- Reset (reset==0 at clk edge):
  - All outputs go to 0 and avst_in_ready=0.
  - Pointers, pkt_cnt and drop_cnt clear; write FSM returns to IDLE.
  - A packet in flight on either side is abandoned.
  - The cycle after release, avst_in_ready=1. It then stays 1 permanently, so the block never backpressures.
- Storage: entry = {sop, eop, empty, channel, data}. Pointers are ADDR_W+1 bits and wrap naturally.
  - wr_ptr: speculative write pointer.
  - wr_base: start of the current packet.
  - rd_ptr: read pointer.
  - used = wr_ptr - rd_ptr. Full when used==DEPTH.
- Write FSM, evaluated on accepted beats (valid & ready):
  - IDLE:
    - sop=1 and not full: store the beat and set wr_base = old wr_ptr.
      - If eop=1 too, commit immediately and stay in IDLE.
      - Otherwise go to WR.
    - sop=1 and full: drop_cnt++, go to DROP (or stay in IDLE if eop=1).
    - sop=0: discard the beat silently; not counted.
  - WR:
    - sop=1 (missing eop): rewind wr_ptr = wr_base, drop_cnt++. Restart handling of this beat as in IDLE within the same cycle.
    - Full (beat does not fit): rewind, drop_cnt++, go to DROP. If the beat carries eop, go to IDLE instead.
    - eop=1: store and commit (pkt_cnt++), go to IDLE.
    - Otherwise: store, stay in WR.
  - DROP: discard beats until eop=1 (go to IDLE). If a sop=1 beat arrives, process it as in IDLE.
- Commit: the packet becomes visible when its eop beat is written, not earlier.
  - A packet longer than DEPTH beats is always dropped.
  - Rewind space is reusable in the next cycle.
- Read side:
  - Registered RAM with one output register (skid) stage.
  - avst_out_valid asserts only while at least one committed beat is buffered ahead of rd_ptr.
  - Latency: eop beat accepted at edge T gives the first beat of that packet on out at edge T+2 minimum, if the output was empty.
  - After the first beat, back-to-back beats are delivered at 1 beat/clk while avst_out_ready=1. A gap between packets is not required.
  - Output fields are held stable while valid & !ready.
  - pkt_cnt decrements when the eop beat is accepted (valid & ready & eop).
  - A commit in the same cycle as an eop read leaves pkt_cnt unchanged.
- drop_cnt saturates at 0xFFFF.
- Channel is passed per beat unchanged. No consistency check within a packet.

Test Plan:
- 3-beat packet (data 0x1..0x3, empty=5 on eop, channel=0xA), out_ready=1 -> out_valid first rises 2 clks after eop accepted. 3 beats in order, sop on beat 0, eop+empty=5 on beat 2, channel=0xA; pkt_cnt 1->0.
- 10-beat packet with out_ready=0 throughout -> out_valid stays 0 until eop accepted, then 1 with beat 0 held stable. Release ready -> 10 consecutive beats.
- DEPTH=64, 70-beat packet followed by a 2-beat packet -> drop_cnt=1, no output from the first; the 2-beat packet is emitted intact.
- sop, 2 beats, then a new sop (no eop) starting a 3-beat packet -> drop_cnt=1; only the 3-beat packet is output.
- Continuous 1-beat packets (sop=eop=1) at 1/clk with random out_ready -> output sequence matches input sequence exactly; drop_cnt=0; pkt_cnt never exceeds 64.
- Assert reset mid-packet on both sides -> next edge out_valid=0, pkt_cnt=0, drop_cnt=0. The next packet after release passes normally.
